falu_arbiter: RTL and testbench

- Shares one combinational floating-point ALU (fALU) between two requesters, e.g. the FP pipeline stage and the FP compare/branch unit.
- Arbitrates with round-robin and registers the operands and op code onto the ALU.
- Holds them for ALU_LAT cycles (multicycle path), captures result and condition flag, returns them over a valid/ready response channel.
- One operation in flight at a time.

---
 rtl/falu_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_falu_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/falu_arbiter.sv
// Round-robin arbiter sharing one combinational fALU between two requesters.
// Operands are held on the ALU for ALU_LAT cycles, then the result is returned on a valid/ready channel.
module falu_arbiter #(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [63:0] resp0_data,
  output logic        resp0_con,
  output logic        resp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [63:0] resp1_data,
  output logic        resp1_con,
  output logic        resp1_err,
  output logic [63:0] alu_in1,
  output logic [63:0] alu_in2,
  output logic [3:0]  alu_control,
  input  logic [63:0] alu_out,
  input  logic        alu_con,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // Requesters hold valid and payload stable until ready; the arbiter holds resp
  // valid/data/con/err stable until the owner's resp_ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_rr_ptr;
  logic        r_owner;
  logic [3:0]  r_cnt;
  logic [63:0] r_alu_in1;
  logic [63:0] r_alu_in2;
  logic [3:0]  r_alu_control;
  logic [63:0] r_resp_data;
  logic        r_resp_con;
  logic        r_resp_err;

  logic        w_any_valid;
  logic        w_grant_idx;
  logic        w_accept;
  logic [3:0]  w_sel_op;
  logic [63:0] w_sel_a;
  logic [63:0] w_sel_b;
  logic        w_resp_hs;
  logic        w_resp0_vld;
  logic        w_resp1_vld;
  logic        w_is_cmp;
  logic [63:0] w_add_data;

  // r_rr_ptr names the requester that wins when both ask in the same cycle.
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    w_grant_idx = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant_idx = r_rr_ptr;
    end else if (req1_valid) begin
      w_grant_idx = 1'b1;
    end
  end

  assign w_accept   = (r_state == S_IDLE) && w_any_valid;
  assign req0_ready = w_accept && !w_grant_idx;
  assign req1_ready = w_accept && w_grant_idx;

  assign w_sel_op = w_grant_idx ? req1_op : req0_op;
  assign w_sel_a  = w_grant_idx ? req1_a  : req0_a;
  assign w_sel_b  = w_grant_idx ? req1_b  : req0_b;

  assign w_resp0_vld = (r_state == S_RESP) && !r_owner;
  assign w_resp1_vld = (r_state == S_RESP) && r_owner;
  assign w_resp_hs   = (w_resp0_vld && resp0_ready) || (w_resp1_vld && resp1_ready);

  // Compare ops return only the flag; single adds drop the forwarded low word.
  assign w_is_cmp   = (r_alu_control[1:0] != 2'b00);
  assign w_add_data = r_alu_control[2] ? alu_out : {alu_out[63:32], 32'h0};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = w_sel_op[3] ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (w_resp_hs) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr      <= 1'b0;
      r_owner       <= 1'b0;
      r_cnt         <= 4'd0;
      r_alu_in1     <= 64'h0;
      r_alu_in2     <= 64'h0;
      r_alu_control <= 4'd0;
      r_resp_data   <= 64'h0;
      r_resp_con    <= 1'b0;
      r_resp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner  <= w_grant_idx;
            r_rr_ptr <= ~w_grant_idx;
            if (w_sel_op[3]) begin
              // Illegal op: answer at once and leave the ALU operands untouched.
              r_resp_data <= 64'h0;
              r_resp_con  <= 1'b0;
              r_resp_err  <= 1'b1;
            end else begin
              r_alu_in1     <= w_sel_a;
              r_alu_in2     <= w_sel_b;
              r_alu_control <= w_sel_op;
              r_cnt         <= CNT_INIT;
            end
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_resp_data <= w_is_cmp ? 64'h0 : w_add_data;
            r_resp_con  <= w_is_cmp ? alu_con : 1'b0;
            r_resp_err  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_in1     = r_alu_in1;
  assign alu_in2     = r_alu_in2;
  assign alu_control = r_alu_control;

  assign resp0_valid = w_resp0_vld;
  assign resp0_data  = w_resp0_vld ? r_resp_data : 64'h0;
  assign resp0_con   = w_resp0_vld & r_resp_con;
  assign resp0_err   = w_resp0_vld & r_resp_err;
  assign resp1_valid = w_resp1_vld;
  assign resp1_data  = w_resp1_vld ? r_resp_data : 64'h0;
  assign resp1_con   = w_resp1_vld & r_resp_con;
  assign resp1_err   = w_resp1_vld & r_resp_err;

  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_falu_arbiter.sv
// Directed bench for falu_arbiter: a tiny fALU stand-in answers the directed vectors,
// and every expected value below is a hand-computed constant.
module tb_falu_arbiter;

  localparam int unsigned ALU_LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_con, resp0_err;
  logic [3:0]  req0_op;
  logic [63:0] req0_a, req0_b, resp0_data;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_con, resp1_err;
  logic [3:0]  req1_op;
  logic [63:0] req1_a, req1_b, resp1_data;
  logic [63:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_control;
  logic        alu_con;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_fail;

  falu_arbiter #(.ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp0_con(resp0_con), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .resp1_con(resp1_con), .resp1_err(resp1_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_out(alu_out), .alu_con(alu_con),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fALU stand-in: known vectors give true IEEE results; compares return junk data
  // so the arbiter's zeroing of compare data is visible.
  always_comb begin
    alu_out = alu_in1 ^ alu_in2;
    alu_con = 1'b0;
    case (alu_control)
      4'b0000: begin
        if (alu_in1[63:32] == 32'h3FA00000 && alu_in2[63:32] == 32'h3F900000)
          alu_out = {32'h40180000, 32'hFFFFFFFF};
        else if (alu_in1[63:32] == 32'h43CE7E70 && alu_in2[63:32] == 32'hC3CE7E70)
          alu_out = {32'h00000000, 32'h12345678};
      end
      4'b0100: begin
        if (alu_in1 == 64'h3FF0000000000000 && alu_in2 == 64'h4000000000000000)
          alu_out = 64'h4008000000000000;
      end
      4'b0001: begin
        alu_out = 64'hDEADDEADDEADDEAD;
        alu_con = (alu_in1[63:32] == alu_in2[63:32]);
      end
      4'b0110: begin
        alu_out = 64'hDEADDEADDEADDEAD;
        alu_con = (alu_in1 < alu_in2);
      end
      default: ;
    endcase
  end

  // Scoreboard check: each call is one comparison.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input int idx, input logic v, input logic [3:0] op,
                           input logic [63:0] a, input logic [63:0] b);
    if (idx == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  function automatic logic rv(input int idx);
    return (idx == 0) ? resp0_valid : resp1_valid;
  endfunction

  // Wait (bounded) for the owner's response; returns edges counted from the accept edge.
  task automatic wait_resp(input int idx, output int lat);
    lat = 1;
    while (!rv(idx) && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake(input int idx, input string tag);
    if (idx == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    chk({tag, "_valid_drop"}, {63'h0, rv(idx)}, 64'h0);
  endtask

  // Driver: one request from a single requester, checked through to its response.
  task automatic run_op(input int idx, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_d,
                        input logic exp_c, input logic exp_e, input int exp_lat,
                        input string tag);
    int lat;
    drive_req(idx, 1'b1, op, a, b);
    #1;
    chk({tag, "_ready"}, {62'h0, req1_ready, req0_ready}, (idx == 0) ? 64'h1 : 64'h2);
    tick();
    drive_req(idx, 1'b0, 4'h0, 64'h0, 64'h0);
    wait_resp(idx, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, (idx == 0) ? resp0_data : resp1_data, exp_d);
    chk({tag, "_con"}, {63'h0, (idx == 0) ? resp0_con : resp1_con}, {63'h0, exp_c});
    chk({tag, "_err"}, {63'h0, (idx == 0) ? resp0_err : resp1_err}, {63'h0, exp_e});
    chk({tag, "_other_valid"}, {63'h0, rv(1 - idx)}, 64'h0);
    handshake(idx, tag);
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    drive_req(0, 1'b0, 4'h0, 64'h0, 64'h0);
    drive_req(1, 1'b0, 4'h0, 64'h0, 64'h0);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_alu_in1", alu_in1, 64'h0);
    chk("rst_alu_ctrl", {60'h0, alu_control}, 64'h0);
    chk("rst_resp_valid", {62'h0, resp1_valid, resp0_valid}, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single add: 1.25 + 1.125 = 2.375; low word forwarded to ALU, zeroed in result
    run_op(0, 4'b0000, 64'h3FA00000_DEADBEEF, 64'h3F900000_12345678,
           64'h40180000_00000000, 1'b0, 1'b0, ALU_LAT + 1, "sadd");
    chk("sadd_alu_in1_hold", alu_in1, 64'h3FA00000_DEADBEEF);
    chk("sadd_alu_in2_hold", alu_in2, 64'h3F900000_12345678);

    // Double add: 1.0 + 2.0 = 3.0 on requester 1
    run_op(1, 4'b0100, 64'h3FF0000000000000, 64'h4000000000000000,
           64'h4008000000000000, 1'b0, 1'b0, ALU_LAT + 1, "dadd");

    // Single compare-equal, then cancelling single add
    run_op(0, 4'b0001, 64'h43CE7E70_00000000, 64'h43CE7E70_00000000,
           64'h0, 1'b1, 1'b0, ALU_LAT + 1, "seq");
    run_op(0, 4'b0000, 64'h43CE7E70_00000000, 64'hC3CE7E70_00000000,
           64'h0, 1'b0, 1'b0, ALU_LAT + 1, "scancel");

    // Round-robin with both requesters always valid (fresh reset -> requester 0 first)
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    drive_req(0, 1'b1, 4'b0100, 64'hA0A0000000000000, 64'h000000000000000F);
    drive_req(1, 1'b1, 4'b0100, 64'h0B0B000000000000, 64'h00000000000000F0);
    for (int k = 0; k < 4; k++) begin
      int w;
      w = k % 2;
      #1;
      chk($sformatf("rr%0d_ready", k), {62'h0, req1_ready, req0_ready},
          (w == 0) ? 64'h1 : 64'h2);
      tick();
      chk($sformatf("rr%0d_exec_ready", k), {62'h0, req1_ready, req0_ready}, 64'h0);
      chk($sformatf("rr%0d_state", k), {62'h0, dbg_state}, 64'h1);
      wait_resp(w, lat);
      chk($sformatf("rr%0d_lat", k), 64'(lat), 64'(ALU_LAT + 1));
      chk($sformatf("rr%0d_data", k), (w == 0) ? resp0_data : resp1_data,
          (w == 0) ? 64'hA0A000000000000F : 64'h0B0B0000000000F0);
      chk($sformatf("rr%0d_other_valid", k), {63'h0, rv(1 - w)}, 64'h0);
      handshake(w, $sformatf("rr%0d", k));
    end
    drive_req(0, 1'b0, 4'h0, 64'h0, 64'h0);
    drive_req(1, 1'b0, 4'h0, 64'h0, 64'h0);
    tick();

    // Back-pressure on a double less-than, with requester 1 waiting on an illegal op
    drive_req(0, 1'b1, 4'b0110, 64'h3FF0000000000000, 64'h4000000000000000);
    #1;
    chk("bp_ready", {62'h0, req1_ready, req0_ready}, 64'h1);
    tick();
    drive_req(0, 1'b0, 4'h0, 64'h0, 64'h0);
    drive_req(1, 1'b1, 4'b1000, 64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA);
    wait_resp(0, lat);
    chk("bp_lat", 64'(lat), 64'(ALU_LAT + 1));
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), {63'h0, resp0_valid}, 64'h1);
      chk($sformatf("bp%0d_data", k), resp0_data, 64'h0);
      chk($sformatf("bp%0d_con", k), {63'h0, resp0_con}, 64'h1);
      chk($sformatf("bp%0d_req1_ready", k), {63'h0, req1_ready}, 64'h0);
      tick();
    end
    resp0_ready = 1'b1;
    #1;
    chk("bp_hs_no_accept", {63'h0, req1_ready}, 64'h0);
    tick();
    resp0_ready = 1'b0;
    chk("bp_valid_drop", {63'h0, resp0_valid}, 64'h0);
    #1;
    chk("ill_ready", {62'h0, req1_ready, req0_ready}, 64'h2);
    tick();
    drive_req(1, 1'b0, 4'h0, 64'h0, 64'h0);
    chk("ill_valid_next", {63'h0, resp1_valid}, 64'h1);
    chk("ill_err", {63'h0, resp1_err}, 64'h1);
    chk("ill_data", resp1_data, 64'h0);
    chk("ill_con", {63'h0, resp1_con}, 64'h0);
    chk("ill_alu_ctrl_kept", {60'h0, alu_control}, 64'h6);
    chk("ill_alu_in1_kept", alu_in1, 64'h3FF0000000000000);
    chk("ill_alu_in2_kept", alu_in2, 64'h4000000000000000);
    handshake(1, "ill");

    // Asynchronous reset in the middle of EXEC
    drive_req(0, 1'b1, 4'b0100, 64'h3FF0000000000000, 64'h4000000000000000);
    tick();
    drive_req(0, 1'b0, 4'h0, 64'h0, 64'h0);
    chk("arst_pre_state", {62'h0, dbg_state}, 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_alu_in1", alu_in1, 64'h0);
    chk("arst_alu_ctrl", {60'h0, alu_control}, 64'h0);
    chk("arst_resp_valid", {62'h0, resp1_valid, resp0_valid}, 64'h0);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("arst_quiet%0d", k), {61'h0, busy, resp1_valid, resp0_valid}, 64'h0);
    end
    run_op(0, 4'b0100, 64'h3FF0000000000000, 64'h4000000000000000,
           64'h4008000000000000, 1'b0, 1'b0, ALU_LAT + 1, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Time limit guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

endmodule
